urv_writeback_nb: RTL and testbench
===================================

Name: urv_writeback_nb

Overview:
- Next-generation uRV writeback stage with non-blocking loads.
- Tracks up to DEPTH outstanding loads in an in-order queue.
- Extracts and sign/zero-extends sub-word load data on return.
- Arbitrates load returns against ALU/shifter/multiplier results onto the single register-file write port, and exports a pending-rd mask for decode interlocks.

Parameters:
- XLEN, 32: datapath width; 32 is the only supported value.
- DEPTH, 4: outstanding-load queue entries; power of 2, from 2 to 16.
- TIMEOUT_CYCLES, 255: load watchdog limit; used only with URV_WB_TIMEOUT_EN.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- w_stall_i  in  1  global stall; blocks acceptance and suppresses the rf write
- w_stall_req_o  out  1  stage cannot accept the current X instruction
- x_valid_i  in  1  X instruction valid
- x_load_i  in  1  instruction is a load
- x_store_i  in  1  instruction is a store
- x_fun_i  in  3  LDST_B/BU/H/HU/L encoding
- x_dm_addr_i  in  2  low bits of the data address
- x_rd_i  in  5  destination register
- x_rd_write_i  in  1  destination write enable
- x_rd_source_i  in  2  RD_SOURCE_* result select
- x_rd_value_i  in  XLEN  ALU result
- x_shifter_rd_value_i  in  XLEN  shifter result
- x_multiply_rd_value_i  in  XLEN  multiplier result
- dm_data_l_i  in  XLEN  load return data
- dm_load_done_i  in  1  returns the oldest outstanding load (1-cycle pulse)
- dm_store_done_i  in  1  store complete
- rf_rd_value_o  out  XLEN  registered write value
- rf_rd_o  out  5  registered write index
- rf_rd_write_o  out  1  registered write strobe
- rd_pending_mask_o  out  32  bit n set = load to xn outstanding
- pending_count_o  out  $clog2(DEPTH)+1  queue occupancy
- load_timeout_o  out  1  watchdog fired (1-cycle pulse)

Behaviour:
- Reset: all outputs 0; queue empty; pointers 0; watchdog counter 0. Reset mid-operation discards queued loads; any late dm_load_done_i is ignored.
- Accept: accept = x_valid_i & !w_stall_i & !w_stall_req_o.
- w_stall_req_o (combinational) is 1 when x_valid_i and any of:
  - a load while the queue is full and no pop occurs this cycle;
  - a store with !dm_store_done_i (stores remain blocking);
  - a non-load with x_rd_write_i and rd_pending_mask_o[x_rd_i] (WAW interlock);
  - a non-load with x_rd_write_i while dm_load_done_i with a non-empty queue (load return owns the port).
- Queue entry: {rd, fun, addr[1:0]}. A load is enqueued on accept; x0 loads are enqueued too, but their write is suppressed. Enqueue and pop in the same cycle are legal when full; occupancy is unchanged.
- Pop: on dm_load_done_i with a non-empty queue, the head entry is removed. dm_load_done_i with an empty queue is ignored.
- Load extraction on head fields:
  - B/BU: byte addr[1:0], sign- or zero-extended.
  - H/HU: half addr[1].
  - L: full word.
  - Other fun values: write value is don't-care but the write still occurs.
- Latency: rf_* are registered one cycle after pop or accept.
  - Load return: rf_rd_write_o = (head.rd != 0).
  - Non-load: rf_rd_write_o = x_rd_write_i & accept.
  - Otherwise rf_rd_write_o = 0 and rf_rd_value_o/rf_rd_o hold.
- rd_pending_mask_o: OR of one-hot(rd) over valid entries, excluding x0; combinational from queue state.
- pending_count_o: registered occupancy, in the range 0..DEPTH.
- Pointers: wrap modulo DEPTH.

Optional Feature:
- URV_WB_TIMEOUT_EN defined: a counter tracks cycles the head entry has been waiting.
  - Reset to 0 on pop, on a new head, or when the queue is empty.
  - On reaching TIMEOUT_CYCLES: pulse load_timeout_o, pop the head with no rf write, clear the counter.
- URV_WB_TIMEOUT_EN undefined: load_timeout_o tied to 0; no counter logic.

Test Plan:
- LB at addr[1:0]=3, dm_data 0x80_12_34_56 → next cycle rf_rd_write_o=1, rf_rd_value_o=0xFFFFFF80; LHU at addr 2 → 0x00008012.
- Issue 4 loads (x1..x4) with no done; a 5th load → w_stall_req_o=1, pending_count_o=4, mask=0x1E. A done pulse in the same cycle → 5th load accepted, count stays 4.
- Load x5 pending, then ADD to x5 → stalled until the x5 load returns; ADD to x6 → accepted, mask=0x20.
- Done pulse coinciding with a valid MUL to x7 → load written first, MUL stalled one cycle, then written with the multiplier value.
- Load to x0 returns → rf_rd_write_o=0, count decrements; done with empty queue → no write, count stays 0.
- Timeout with TIMEOUT_CYCLES=8 and macro defined: load pending 8 cycles → load_timeout_o pulses once, count 1→0, no rf write. Without macro: still pending, load_timeout_o=0.

Source files
------------

// File: rtl/urv_writeback_nb.sv
// urv_writeback_nb: uRV writeback stage with non-blocking loads.
//
// Loads are recorded in a small in-order queue when accepted. Their data is
// extracted and written back whenever memory signals completion. ALU, shifter
// and multiplier results are written back one cycle after acceptance. A load
// return always wins the single register-file write port.
//
// Optional build macro: URV_WB_TIMEOUT_EN enables a watchdog that drops a
// load whose return has not arrived within TIMEOUT_CYCLES cycles.
//
// Handshake: the X stage offers an instruction with x_valid_i. The
// instruction is taken in a cycle where x_valid_i is high, w_stall_i is low
// and w_stall_req_o is low. w_stall_req_o depends only on the offered
// instruction and on the current queue and memory state. It never depends on
// w_stall_i, so the offer may stay in place until it is taken.

module urv_writeback_nb #(
    parameter int XLEN           = 32,
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     w_stall_i,
    output logic                     w_stall_req_o,
    input  logic                     x_valid_i,
    input  logic                     x_load_i,
    input  logic                     x_store_i,
    input  logic [2:0]               x_fun_i,
    input  logic [1:0]               x_dm_addr_i,
    input  logic [4:0]               x_rd_i,
    input  logic                     x_rd_write_i,
    input  logic [1:0]               x_rd_source_i,
    input  logic [XLEN-1:0]          x_rd_value_i,
    input  logic [XLEN-1:0]          x_shifter_rd_value_i,
    input  logic [XLEN-1:0]          x_multiply_rd_value_i,
    input  logic [XLEN-1:0]          dm_data_l_i,
    input  logic                     dm_load_done_i,
    input  logic                     dm_store_done_i,
    output logic [XLEN-1:0]          rf_rd_value_o,
    output logic [4:0]               rf_rd_o,
    output logic                     rf_rd_write_o,
    output logic [31:0]              rd_pending_mask_o,
    output logic [$clog2(DEPTH):0]   pending_count_o,
    output logic                     load_timeout_o
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] RD_SOURCE_ALU      = 2'd0;
    localparam logic [1:0] RD_SOURCE_SHIFTER  = 2'd1;
    localparam logic [1:0] RD_SOURCE_MULTIPLY = 2'd2;

    // Outstanding-load queue: one entry holds {rd, fun, addr[1:0]}.
    logic [4:0]       q_rd   [DEPTH];
    logic [2:0]       q_fun  [DEPTH];
    logic [1:0]       q_addr [DEPTH];
    logic [DEPTH-1:0] q_valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    q_count;

    logic q_empty;
    logic q_full;
    logic done_pop;
    logic timeout_pop;
    logic pop;
    logic push;
    logic accept;
    logic stall_full;
    logic stall_store;
    logic stall_waw;
    logic stall_port;

    logic [4:0]      head_rd;
    logic [2:0]      head_fun;
    logic [1:0]      head_addr;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_value;
    logic [XLEN-1:0] x_result;

    assign q_empty  = (q_count == '0);
    assign q_full   = (q_count == CW'(DEPTH));
    // A completion with nothing outstanding is stale and is dropped.
    assign done_pop = dm_load_done_i & ~q_empty;
    assign pop      = done_pop | timeout_pop;

    assign stall_full  = x_load_i & q_full & ~pop;
    assign stall_store = x_store_i & ~dm_store_done_i;
    assign stall_waw   = ~x_load_i & x_rd_write_i & rd_pending_mask_o[x_rd_i];
    assign stall_port  = ~x_load_i & x_rd_write_i & done_pop;

    assign w_stall_req_o = x_valid_i & (stall_full | stall_store | stall_waw | stall_port);
    assign accept        = x_valid_i & ~w_stall_i & ~w_stall_req_o;
    assign push          = accept & x_load_i;

    assign head_rd   = q_rd[rd_ptr];
    assign head_fun  = q_fun[rd_ptr];
    assign head_addr = q_addr[rd_ptr];

    assign pending_count_o = q_count;

    // Queue payload storage; validity is tracked separately so no reset is needed here.
    always_ff @(posedge clk_i) begin
        if (push) begin
            q_rd[wr_ptr]   <= x_rd_i;
            q_fun[wr_ptr]  <= x_fun_i;
            q_addr[wr_ptr] <= x_dm_addr_i;
        end
    end

    // Queue pointers, occupancy and per-entry valid bits.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            q_count <= '0;
            q_valid <= '0;
        end else begin
            // Clear before set: a push and a pop on a full queue share one slot.
            if (pop)
                q_valid[rd_ptr] <= 1'b0;
            if (push)
                q_valid[wr_ptr] <= 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            case ({push, pop})
                2'b10:   q_count <= q_count + 1'b1;
                2'b01:   q_count <= q_count - 1'b1;
                default: q_count <= q_count;
            endcase
        end
    end

    // Pending-destination mask for decode interlocks; x0 never blocks anything.
    always_comb begin
        rd_pending_mask_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (q_valid[i] && (q_rd[i] != 5'd0))
                rd_pending_mask_o[q_rd[i]] = 1'b1;
        end
    end

    // Sub-word extraction of the returning load, driven by the head entry.
    always_comb begin
        ld_byte    = 8'h00;
        ld_half    = head_addr[1] ? dm_data_l_i[31:16] : dm_data_l_i[15:0];
        load_value = dm_data_l_i;
        case (head_addr)
            2'd0:    ld_byte = dm_data_l_i[7:0];
            2'd1:    ld_byte = dm_data_l_i[15:8];
            2'd2:    ld_byte = dm_data_l_i[23:16];
            default: ld_byte = dm_data_l_i[31:24];
        endcase
        case (head_fun)
            LDST_B:  load_value = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            LDST_BU: load_value = {{(XLEN-8){1'b0}}, ld_byte};
            LDST_H:  load_value = {{(XLEN-16){ld_half[15]}}, ld_half};
            LDST_HU: load_value = {{(XLEN-16){1'b0}}, ld_half};
            LDST_L:  load_value = dm_data_l_i;
            default: load_value = dm_data_l_i;
        endcase
    end

    // Result select for non-load instructions.
    always_comb begin
        x_result = x_rd_value_i;
        case (x_rd_source_i)
            RD_SOURCE_SHIFTER:  x_result = x_shifter_rd_value_i;
            RD_SOURCE_MULTIPLY: x_result = x_multiply_rd_value_i;
            default:            x_result = x_rd_value_i;
        endcase
    end

    // Register-file write port: a load return has priority over the X result.
    // A load return is written even under w_stall_i because memory signals
    // completion only once.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            rf_rd_value_o <= '0;
            rf_rd_o       <= '0;
            rf_rd_write_o <= 1'b0;
        end else if (done_pop) begin
            rf_rd_value_o <= load_value;
            rf_rd_o       <= head_rd;
            rf_rd_write_o <= (head_rd != 5'd0);
        end else if (accept && !x_load_i && x_rd_write_i) begin
            rf_rd_value_o <= x_result;
            rf_rd_o       <= x_rd_i;
            rf_rd_write_o <= 1'b1;
        end else begin
            rf_rd_write_o <= 1'b0;
        end
    end

`ifdef URV_WB_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [WD_W-1:0] wd_cnt;

    // The head has waited long enough once the counter reaches the limit on this edge.
    assign timeout_pop = ~q_empty & ~done_pop & (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Head-wait watchdog; restarts for every new head and idles on an empty queue.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wd_cnt         <= '0;
            load_timeout_o <= 1'b0;
        end else begin
            load_timeout_o <= timeout_pop;
            if (q_empty || pop)
                wd_cnt <= '0;
            else
                wd_cnt <= wd_cnt + 1'b1;
        end
    end
`else
    assign timeout_pop    = 1'b0;
    assign load_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_urv_writeback_nb.sv
// tb_urv_writeback_nb: self-checking bench for urv_writeback_nb.
// The timeout sequence checks the URV_WB_TIMEOUT_EN behaviour when that macro
// is defined, and checks the plain non-blocking behaviour otherwise.

module tb_urv_writeback_nb;

    localparam int XLEN  = 32;
    localparam int DEPTH = 4;

    localparam logic [2:0] LDST_B  = 3'b000;
    localparam logic [2:0] LDST_H  = 3'b001;
    localparam logic [2:0] LDST_L  = 3'b010;
    localparam logic [2:0] LDST_BU = 3'b100;
    localparam logic [2:0] LDST_HU = 3'b101;

    localparam logic [1:0] SRC_ALU = 2'd0;
    localparam logic [1:0] SRC_SH  = 2'd1;
    localparam logic [1:0] SRC_MUL = 2'd2;

    logic                   clk_i = 1'b0;
    logic                   rst_n_i = 1'b0;
    logic                   w_stall_i;
    logic                   w_stall_req_o;
    logic                   x_valid_i;
    logic                   x_load_i;
    logic                   x_store_i;
    logic [2:0]             x_fun_i;
    logic [1:0]             x_dm_addr_i;
    logic [4:0]             x_rd_i;
    logic                   x_rd_write_i;
    logic [1:0]             x_rd_source_i;
    logic [XLEN-1:0]        x_rd_value_i;
    logic [XLEN-1:0]        x_shifter_rd_value_i;
    logic [XLEN-1:0]        x_multiply_rd_value_i;
    logic [XLEN-1:0]        dm_data_l_i;
    logic                   dm_load_done_i;
    logic                   dm_store_done_i;
    logic [XLEN-1:0]        rf_rd_value_o;
    logic [4:0]             rf_rd_o;
    logic                   rf_rd_write_o;
    logic [31:0]            rd_pending_mask_o;
    logic [$clog2(DEPTH):0] pending_count_o;
    logic                   load_timeout_o;

    int checks = 0;
    int errors = 0;

    // Expected register-file writes, {rd, value}, in write order.
    logic [36:0] exp_q[$];
    logic [36:0] mon_e;

    typedef struct {
        logic [2:0]  fun;
        logic [1:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } ld_vec_t;

    ld_vec_t    ld_vec [12];
    logic [4:0] drain_rd [4];
    logic [31:0] src_exp [3];

    urv_writeback_nb #(
        .XLEN(XLEN),
        .DEPTH(DEPTH),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i                 (clk_i),
        .rst_n_i               (rst_n_i),
        .w_stall_i             (w_stall_i),
        .w_stall_req_o         (w_stall_req_o),
        .x_valid_i             (x_valid_i),
        .x_load_i              (x_load_i),
        .x_store_i             (x_store_i),
        .x_fun_i               (x_fun_i),
        .x_dm_addr_i           (x_dm_addr_i),
        .x_rd_i                (x_rd_i),
        .x_rd_write_i          (x_rd_write_i),
        .x_rd_source_i         (x_rd_source_i),
        .x_rd_value_i          (x_rd_value_i),
        .x_shifter_rd_value_i  (x_shifter_rd_value_i),
        .x_multiply_rd_value_i (x_multiply_rd_value_i),
        .dm_data_l_i           (dm_data_l_i),
        .dm_load_done_i        (dm_load_done_i),
        .dm_store_done_i       (dm_store_done_i),
        .rf_rd_value_o         (rf_rd_value_o),
        .rf_rd_o               (rf_rd_o),
        .rf_rd_write_o         (rf_rd_write_o),
        .rd_pending_mask_o     (rd_pending_mask_o),
        .pending_count_o       (pending_count_o),
        .load_timeout_o        (load_timeout_o)
    );

    // Clock generation.
    always #5 clk_i = ~clk_i;

    // Overall time limit so the run always ends.
    initial begin
        #1000000;
        $display("FAIL time_limit: got no end of test, required end before 1000000");
        $fatal(1, "time limit");
    end

    // Compare one observed value against its required value.
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_idle();
        w_stall_i             = 1'b0;
        x_valid_i             = 1'b0;
        x_load_i              = 1'b0;
        x_store_i             = 1'b0;
        x_fun_i               = 3'b000;
        x_dm_addr_i           = 2'b00;
        x_rd_i                = 5'd0;
        x_rd_write_i          = 1'b0;
        x_rd_source_i         = SRC_ALU;
        x_rd_value_i          = '0;
        x_shifter_rd_value_i  = '0;
        x_multiply_rd_value_i = '0;
        dm_data_l_i           = '0;
        dm_load_done_i        = 1'b0;
        dm_store_done_i       = 1'b0;
    endtask

    task automatic drive_load(input logic [4:0] rd, input logic [2:0] fun, input logic [1:0] addr);
        x_valid_i    = 1'b1;
        x_load_i     = 1'b1;
        x_store_i    = 1'b0;
        x_fun_i      = fun;
        x_dm_addr_i  = addr;
        x_rd_i       = rd;
        x_rd_write_i = 1'b1;
    endtask

    task automatic drive_alu(input logic [4:0] rd, input logic [1:0] src,
                             input logic [31:0] alu, input logic [31:0] sh, input logic [31:0] mul);
        x_valid_i             = 1'b1;
        x_load_i              = 1'b0;
        x_store_i             = 1'b0;
        x_rd_i                = rd;
        x_rd_write_i          = 1'b1;
        x_rd_source_i         = src;
        x_rd_value_i          = alu;
        x_shifter_rd_value_i  = sh;
        x_multiply_rd_value_i = mul;
    endtask

    task automatic expect_write(input logic [4:0] rd, input logic [31:0] value);
        exp_q.push_back({rd, value});
    endtask

    // Scoreboard: every register-file write must match the oldest expectation.
    always @(negedge clk_i) begin
        if (rst_n_i && rf_rd_write_o) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd %0d value 0x%08h, required no write",
                         rf_rd_o, rf_rd_value_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("rf_rd", 32'(rf_rd_o), 32'(mon_e[36:32]));
                check("rf_value", rf_rd_value_o, mon_e[31:0]);
            end
        end
    end

    initial begin
        ld_vec[0]  = '{LDST_B,  2'd3, 32'h8012_3456, 32'hFFFF_FF80};
        ld_vec[1]  = '{LDST_HU, 2'd2, 32'h8012_3456, 32'h0000_8012};
        ld_vec[2]  = '{LDST_BU, 2'd3, 32'h8012_3456, 32'h0000_0080};
        ld_vec[3]  = '{LDST_B,  2'd0, 32'h8012_3456, 32'h0000_0056};
        ld_vec[4]  = '{LDST_B,  2'd1, 32'h0000_B400, 32'hFFFF_FFB4};
        ld_vec[5]  = '{LDST_BU, 2'd2, 32'h00C3_0000, 32'h0000_00C3};
        ld_vec[6]  = '{LDST_H,  2'd0, 32'h1234_F00D, 32'hFFFF_F00D};
        ld_vec[7]  = '{LDST_H,  2'd2, 32'h7FFF_0000, 32'h0000_7FFF};
        ld_vec[8]  = '{LDST_HU, 2'd0, 32'hABCD_8001, 32'h0000_8001};
        ld_vec[9]  = '{LDST_L,  2'd0, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
        ld_vec[10] = '{LDST_B,  2'd2, 32'h007F_0000, 32'h0000_007F};
        ld_vec[11] = '{LDST_H,  2'd2, 32'h8000_1234, 32'hFFFF_8000};
        drain_rd   = '{5'd2, 5'd3, 5'd4, 5'd8};
        src_exp    = '{32'hA000_0000, 32'h5000_000B, 32'h0000_C00C};

        // Reset.
        drive_idle();
        rst_n_i = 1'b0;
        repeat (3) tick();
        check("rst_rf_value", rf_rd_value_o, 32'h0);
        check("rst_rf_rd", 32'(rf_rd_o), 32'h0);
        check("rst_rf_write", 32'(rf_rd_write_o), 32'h0);
        check("rst_mask", rd_pending_mask_o, 32'h0);
        check("rst_count", 32'(pending_count_o), 32'h0);
        check("rst_timeout", 32'(load_timeout_o), 32'h0);
        check("rst_stall_req", 32'(w_stall_req_o), 32'h0);
        rst_n_i = 1'b1;
        tick();

        // Load extraction table: issue, then return one cycle later.
        for (int i = 0; i < 12; i++) begin
            drive_load(5'(i + 1), ld_vec[i].fun, ld_vec[i].addr);
            #1;
            check("ld_accept", 32'(w_stall_req_o), 32'h0);
            tick();
            drive_idle();
            check("ld_count", 32'(pending_count_o), 32'd1);
            check("ld_mask", rd_pending_mask_o, 32'h1 << (i + 1));
            dm_load_done_i = 1'b1;
            dm_data_l_i    = ld_vec[i].data;
            expect_write(5'(i + 1), ld_vec[i].exp);
            tick();
            drive_idle();
            check("ld_drained", 32'(pending_count_o), 32'd0);
        end

        // Fill the queue, stall the fifth load, then accept it alongside a pop.
        for (int r = 1; r <= 4; r++) begin
            drive_load(5'(r), LDST_L, 2'd0);
            #1;
            check("fill_accept", 32'(w_stall_req_o), 32'h0);
            tick();
        end
        drive_load(5'd8, LDST_L, 2'd0);
        #1;
        check("full_stall", 32'(w_stall_req_o), 32'h1);
        check("full_count", 32'(pending_count_o), 32'd4);
        check("full_mask", rd_pending_mask_o, 32'h0000_001E);
        tick();
        check("full_hold_count", 32'(pending_count_o), 32'd4);
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h1111_1111;
        expect_write(5'd1, 32'h1111_1111);
        #1;
        check("full_pop_accept", 32'(w_stall_req_o), 32'h0);
        tick();
        drive_idle();
        check("full_swap_count", 32'(pending_count_o), 32'd4);
        check("full_swap_mask", rd_pending_mask_o, 32'h0000_011C);
        for (int k = 0; k < 4; k++) begin
            dm_load_done_i = 1'b1;
            dm_data_l_i    = 32'h0101_0101 * (k + 2);
            expect_write(drain_rd[k], 32'h0101_0101 * (k + 2));
            tick();
        end
        drive_idle();
        check("drain_count", 32'(pending_count_o), 32'd0);
        check("drain_mask", rd_pending_mask_o, 32'h0);

        // WAW interlock: x5 load pending; x6 proceeds, x5 waits for the return.
        drive_load(5'd5, LDST_L, 2'd0);
        tick();
        drive_idle();
        drive_alu(5'd6, SRC_ALU, 32'h0000_0066, 32'h0, 32'h0);
        #1;
        check("waw_other_accept", 32'(w_stall_req_o), 32'h0);
        check("waw_mask", rd_pending_mask_o, 32'h0000_0020);
        expect_write(5'd6, 32'h0000_0066);
        tick();
        drive_alu(5'd5, SRC_ALU, 32'h0000_0055, 32'h0, 32'h0);
        #1;
        check("waw_stall", 32'(w_stall_req_o), 32'h1);
        tick();
        check("waw_stall_hold", 32'(w_stall_req_o), 32'h1);
        tick();
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'hA5A5_A5A5;
        expect_write(5'd5, 32'hA5A5_A5A5);
        #1;
        check("waw_port_stall", 32'(w_stall_req_o), 32'h1);
        tick();
        dm_load_done_i = 1'b0;
        #1;
        check("waw_release", 32'(w_stall_req_o), 32'h0);
        expect_write(5'd5, 32'h0000_0055);
        tick();
        drive_idle();

        // Load return coinciding with a multiply: load first, multiply next cycle.
        drive_load(5'd9, LDST_L, 2'd0);
        tick();
        drive_idle();
        drive_alu(5'd7, SRC_MUL, 32'h0000_0001, 32'h0000_0002, 32'h7777_7777);
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h0000_0099;
        expect_write(5'd9, 32'h0000_0099);
        #1;
        check("mul_port_stall", 32'(w_stall_req_o), 32'h1);
        tick();
        dm_load_done_i = 1'b0;
        #1;
        check("mul_accept", 32'(w_stall_req_o), 32'h0);
        expect_write(5'd7, 32'h7777_7777);
        tick();
        drive_idle();

        // Result source select.
        for (int s = 0; s < 3; s++) begin
            drive_alu(5'(10 + s), 2'(s), 32'hA000_0000, 32'h5000_000B, 32'h0000_C00C);
            expect_write(5'(10 + s), src_exp[s]);
            tick();
        end
        drive_idle();

        // Load to x0: no write but occupancy tracks it; stale done is ignored.
        drive_load(5'd0, LDST_L, 2'd0);
        tick();
        drive_idle();
        check("x0_count", 32'(pending_count_o), 32'd1);
        check("x0_mask", rd_pending_mask_o, 32'h0);
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h0000_FFFF;
        tick();
        check("x0_popped", 32'(pending_count_o), 32'd0);
        check("x0_no_write", 32'(rf_rd_write_o), 32'h0);
        tick();
        check("empty_done_count", 32'(pending_count_o), 32'd0);
        check("empty_done_no_write", 32'(rf_rd_write_o), 32'h0);
        drive_idle();

        // Stores block until the store completes.
        x_valid_i = 1'b1;
        x_store_i = 1'b1;
        #1;
        check("store_stall", 32'(w_stall_req_o), 32'h1);
        dm_store_done_i = 1'b1;
        #1;
        check("store_done", 32'(w_stall_req_o), 32'h0);
        tick();
        drive_idle();

        // Global stall blocks acceptance and the write.
        drive_alu(5'd14, SRC_ALU, 32'h0000_00EE, 32'h0, 32'h0);
        w_stall_i = 1'b1;
        tick();
        check("wstall_no_write", 32'(rf_rd_write_o), 32'h0);
        w_stall_i = 1'b0;
        expect_write(5'd14, 32'h0000_00EE);
        tick();
        drive_idle();

        // Watchdog: a load left waiting for 8 cycles.
        drive_load(5'd12, LDST_L, 2'd0);
        tick();
        drive_idle();
        for (int c = 1; c < 8; c++) begin
            tick();
            check("wd_wait_timeout", 32'(load_timeout_o), 32'h0);
            check("wd_wait_count", 32'(pending_count_o), 32'd1);
        end
        tick();
        check("wd_no_write", 32'(rf_rd_write_o), 32'h0);
`ifdef URV_WB_TIMEOUT_EN
        check("wd_pulse", 32'(load_timeout_o), 32'h1);
        check("wd_count", 32'(pending_count_o), 32'd0);
        tick();
        check("wd_pulse_once", 32'(load_timeout_o), 32'h0);
`else
        check("wd_pulse", 32'(load_timeout_o), 32'h0);
        check("wd_count", 32'(pending_count_o), 32'd1);
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h0000_C0DE;
        expect_write(5'd12, 32'h0000_C0DE);
        tick();
        drive_idle();
        check("wd_late_count", 32'(pending_count_o), 32'd0);
`endif

        // Reset with a load outstanding discards it; its late return is ignored.
        drive_load(5'd13, LDST_L, 2'd0);
        tick();
        drive_idle();
        rst_n_i = 1'b0;
        #2;
        check("midrst_count", 32'(pending_count_o), 32'd0);
        check("midrst_mask", rd_pending_mask_o, 32'h0);
        rst_n_i = 1'b1;
        dm_load_done_i = 1'b1;
        dm_data_l_i    = 32'h1313_1313;
        tick();
        check("midrst_late_count", 32'(pending_count_o), 32'd0);
        check("midrst_late_write", 32'(rf_rd_write_o), 32'h0);
        drive_idle();

        repeat (2) tick();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
